// File: rtl/prog_loader.sv
// Program loader: streams DEPTH host words into RAM while the CPU is held,
// then releases the CPU. The optional readback pass (macro
// PROG_LOADER_READBACK_EN) re-reads every word and flags a checksum mismatch on err.
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, VERIFY, DONE} state_t;

  state_t            state, next;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] csum;
  logic              enter_load;

  assign enter_load = ((state == IDLE) || (state == DONE)) && start;

`ifdef PROG_LOADER_READBACK_EN
  logic [ADDR_W:0]   rd_idx;   // next read address; MSB set once all reads issued
  logic              rd_pend;  // a read issued last cycle, data on ram_rdata now
  logic [DATA_W-1:0] acc;
  logic              err_q;
  logic              rd_last;
  assign rd_last = rd_idx[ADDR_W] && !rd_pend;
  assign err     = err_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
  assign err          = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  // Next-state and Moore output decode
  always_comb begin
    next     = state;
    in_ready = 1'b0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    ram_addr = wr_addr;
    case (state)
      IDLE:  if (start) next = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) next = WRITE;
      end
      WRITE: begin
        ram_we = 1'b1;
        if (count == LAST) begin
`ifdef PROG_LOADER_READBACK_EN
          next = VERIFY;
`else
          next = DONE;
`endif
        end else begin
          next = LOAD;
        end
      end
`ifdef PROG_LOADER_READBACK_EN
      VERIFY: begin
        ram_re   = !rd_idx[ADDR_W];
        ram_addr = rd_idx[ADDR_W-1:0];
        if (rd_last) next = DONE;
      end
`endif
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) next = LOAD;
      end
      default: next = IDLE;
    endcase
  end

  // Write datapath: capture accepted word, running XOR checksum, word count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      csum      <= '0;
      wr_addr   <= '0;
      ram_wdata <= '0;
    end else begin
      if (enter_load) begin
        count <= '0;
        csum  <= '0;
      end
      if (state == LOAD && in_valid) begin
        ram_wdata <= in_data;
        wr_addr   <= count[ADDR_W-1:0];
        csum      <= csum ^ in_data;
      end
      if (state == WRITE) count <= count + ONE;
    end
  end

`ifdef PROG_LOADER_READBACK_EN
  // Readback pass: issue reads back-to-back, fold returned data, compare at end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx  <= '0;
      rd_pend <= 1'b0;
      acc     <= '0;
      err_q   <= 1'b0;
    end else begin
      if (enter_load) err_q <= 1'b0;
      if (state == WRITE && next == VERIFY) begin
        rd_idx  <= '0;
        rd_pend <= 1'b0;
        acc     <= '0;
      end
      if (state == VERIFY) begin
        if (!rd_idx[ADDR_W]) rd_idx <= rd_idx + ONE;
        rd_pend <= ram_re;
        if (rd_pend) acc <= acc ^ ram_rdata;
        if (rd_last) err_q <= (acc != csum);
      end
    end
  end
`endif
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a behavioural RAM and write/read monitor.
module tb_prog_loader;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
`ifdef PROG_LOADER_READBACK_EN
  localparam int FULL_DONE = 52;  // 34 + 16 read cycles + 2 drain/compare
`else
  localparam int FULL_DONE = 34;  // start cycle = 1, 16 words x 2 cycles
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   count;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [DEPTH];
  int                we_cnt [DEPTH];
  logic [DATA_W-1:0] we_data [DEPTH];
  int                we_total = 0;
  int                re_total = 0;
  int                order_bad = 0;
  int                both_seen = 0;
  bit                corrupt = 1'b0;

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata), .cpu_hold(cpu_hold), .done(done), .err(err),
    .count(count)
  );

  always #5 clk = ~clk;

  // RAM model plus write-order / strobe monitor
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      we_cnt[ram_addr] = we_cnt[ram_addr] + 1;
      we_data[ram_addr] = ram_wdata;
      if (int'(ram_addr) != we_total) order_bad = order_bad + 1;
      we_total = we_total + 1;
    end
    if (ram_re) begin
      re_total = re_total + 1;
      ram_rdata <= mem[ram_addr] ^ ((corrupt && ram_addr == 4'd5) ? 8'h80 : 8'h00);
    end
    if (ram_we && ram_re) both_seen = both_seen + 1;
  end

  task automatic clear_log();
    for (int i = 0; i < DEPTH; i++) begin
      we_cnt[i] = 0;
      we_data[i] = '0;
    end
    we_total = 0;
    re_total = 0;
    order_bad = 0;
  endtask

  // Number of addresses not written exactly once with base+addr
  function automatic int log_bad(input logic [DATA_W-1:0] base);
    int n = 0;
    for (int i = 0; i < DEPTH; i++)
      if (we_cnt[i] != 1 || we_data[i] !== base + 8'(i)) n++;
    return n;
  endfunction

  // Pulse start at cycle 1 (and at start_at if nonzero), stream base+w words.
  // done_cyc is the first cycle (start cycle = 1) in which done is high; 0 if none.
  task automatic do_load(input logic [DATA_W-1:0] base, input bit toggle,
                         input int start_at, input int budget, output int done_cyc);
    int w = 0;
    bit acc = 1'b0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (acc) w++;
      if (cyc > 1 && done) begin
        done_cyc = cyc;
        break;
      end
      start    = (cyc == 1) || (cyc == start_at);
      in_valid = toggle ? (((cyc - 1) / 3) % 2 == 0) : 1'b1;
      if (w >= DEPTH) in_valid = 1'b0;
      in_data  = base + 8'(w);
      acc      = in_ready && in_valid;
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold got %b want 1", cpu_hold); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err got %b%b want 00", done, err); end
    checks++; if (in_ready !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b%b%b want 000", in_ready, ram_we, ram_re); end
    checks++; if (ram_addr !== 4'd0 || ram_wdata !== 8'd0 || count !== 5'd0) begin errors++; $display("FAIL reset_regs got a=%0h d=%0h c=%0d want 0", ram_addr, ram_wdata, count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_load();
    int dc;
    clear_log();
    do_load(8'h10, 1'b0, 0, 80, dc);
    checks++; if (dc != FULL_DONE) begin errors++; $display("FAIL full_done_cycle got %0d want %0d", dc, FULL_DONE); end
    checks++; if (cpu_hold !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL full_release got hold=%b done=%b want 0 1", cpu_hold, done); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count got %0d want 16", count); end
    checks++; if (we_total != 16 || order_bad != 0) begin errors++; $display("FAIL full_writes got %0d order_bad=%0d want 16 0", we_total, order_bad); end
    checks++; if (log_bad(8'h10) != 0) begin errors++; $display("FAIL full_data got %0d bad addrs want 0", log_bad(8'h10)); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err got %b want 0", err); end
  endtask

  task automatic test_backpressure();
    int dc;
    clear_log();
    do_load(8'hA0, 1'b1, 0, 300, dc);
    checks++; if (dc == 0 || done !== 1'b1) begin errors++; $display("FAIL bp_done got cyc=%0d done=%b want done", dc, done); end
    checks++; if (we_total != 16 || order_bad != 0) begin errors++; $display("FAIL bp_writes got %0d order_bad=%0d want 16 0", we_total, order_bad); end
    checks++; if (log_bad(8'hA0) != 0) begin errors++; $display("FAIL bp_data got %0d bad addrs want 0", log_bad(8'hA0)); end
  endtask

  task automatic test_start_pulses();
    int dc;
    clear_log();
    // restart from DONE
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL restart_hold got hold=%b done=%b want 1 0", cpu_hold, done); end
    checks++; if (in_ready !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL restart_load got rdy=%b cnt=%0d want 1 0", in_ready, count); end
    // already in LOAD: both start pulses in do_load must be ignored
    do_load(8'h60, 1'b0, 8, 80, dc);
    checks++; if (done !== 1'b1 || count !== 5'd16) begin errors++; $display("FAIL startload_done got done=%b cnt=%0d want 1 16", done, count); end
    checks++; if (we_total != 16 || order_bad != 0) begin errors++; $display("FAIL startload_writes got %0d order_bad=%0d want 16 0", we_total, order_bad); end
    checks++; if (log_bad(8'h60) != 0) begin errors++; $display("FAIL startload_data got %0d bad addrs want 0", log_bad(8'h60)); end
  endtask

  task automatic test_reset_mid();
    int dc;
    clear_log();
    do_load(8'h50, 1'b0, 0, 16, dc);   // 7 words written by cycle 16
    checks++; if (count !== 5'd7 || we_total != 7) begin errors++; $display("FAIL mid_count got cnt=%0d wr=%0d want 7 7", count, we_total); end
    rst_n = 1'b0;
    #1;
    checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL mid_reset got hold=%b done=%b cnt=%0d want 1 0 0", cpu_hold, done, count); end
    checks++; if (in_ready !== 1'b0 || ram_addr !== 4'd0 || ram_wdata !== 8'd0) begin errors++; $display("FAIL mid_reset_regs got rdy=%b a=%0h d=%0h want 0", in_ready, ram_addr, ram_wdata); end
    @(negedge clk); rst_n = 1'b1;
    clear_log();
    do_load(8'h30, 1'b0, 0, 80, dc);
    checks++; if (dc != FULL_DONE) begin errors++; $display("FAIL reload_done_cycle got %0d want %0d", dc, FULL_DONE); end
    checks++; if (order_bad != 0 || log_bad(8'h30) != 0) begin errors++; $display("FAIL reload_data got order_bad=%0d bad=%0d want 0 0", order_bad, log_bad(8'h30)); end
  endtask

  task automatic test_readback();
`ifdef PROG_LOADER_READBACK_EN
    int dc;
    corrupt = 1'b1;
    clear_log();
    do_load(8'h10, 1'b0, 0, 100, dc);
    checks++; if (err !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL rb_corrupt got err=%b done=%b want 1 1", err, done); end
    checks++; if (re_total != 16) begin errors++; $display("FAIL rb_reads got %0d want 16", re_total); end
    corrupt = 1'b0;
    clear_log();
    do_load(8'h10, 1'b0, 0, 100, dc);
    checks++; if (err !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL rb_clean got err=%b done=%b want 0 1", err, done); end
`else
    checks++; if (err !== 1'b0 || re_total != 0) begin errors++; $display("FAIL no_rb got err=%b reads=%0d want 0 0", err, re_total); end
`endif
    checks++; if (both_seen != 0) begin errors++; $display("FAIL we_re_overlap got %0d want 0", both_seen); end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_full_load();
    test_backpressure();
    test_start_pulses();
    test_reset_mid();
    test_readback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
